exe_stage: RTL

Execute stage of the 5-stage in-order pipeline, between the decode stage and the memory stage.
- Runs ALU and multiply operations in one cycle and 32-bit divide/modulo through an iterative radix-2 divider.
- Issues the data-SRAM request (load/store byte-enables, aligned write data).
- Sends the memory stage its 76-bit bus and the decode stage its forwarding and stall signals.

---
 rtl/exe_stage_pkg.sv | 68 ++++++
 rtl/alu.sv | 36 +++
 rtl/div_iter.sv | 102 ++++++++++
 rtl/exe_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, op-field bit indices,
// the decode->execute payload layout and store lane helpers.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_BUS_WD = 162;
  localparam int unsigned ES_TO_MS_BUS_WD = 76;
  localparam int unsigned DIV_ITER        = 32;
  localparam int unsigned DIV_CNT_W       = $clog2(DIV_ITER);

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  localparam int unsigned MD_MUL   = 6;
  localparam int unsigned MD_MULH  = 5;
  localparam int unsigned MD_MULHU = 4;
  localparam int unsigned MD_DIV   = 3;
  localparam int unsigned MD_MOD   = 2;
  localparam int unsigned MD_DIVU  = 1;
  localparam int unsigned MD_MODU  = 0;

  localparam int unsigned ST_B = 2;
  localparam int unsigned ST_H = 1;
  localparam int unsigned ST_W = 0;

  typedef struct packed {
    logic [11:0] alu_op;
    logic [6:0]  md_op;
    logic [4:0]  ld_op;
    logic [2:0]  st_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_bus_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [3:0] st_mask(input logic [2:0] st_op, input logic [1:0] addr_lo);
    if (st_op[ST_B])      st_mask = 4'b0001 << addr_lo;
    else if (st_op[ST_H]) st_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
    else if (st_op[ST_W]) st_mask = 4'b1111;
    else                  st_mask = 4'b0000;
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] st_op, input logic [31:0] rkd);
    if (st_op[ST_B])      st_data = {4{rkd[7:0]}};
    else if (st_op[ST_H]) st_data = {2{rkd[15:0]}};
    else                  st_data = rkd;
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU driven by a one-hot operation vector.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sra_res;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
  assign sltu_res = {31'd0, alu_src1 < alu_src2};
  assign sra_res  = 32'($signed(alu_src1) >>> alu_src2[4:0]);

  assign alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
                    | ({32{alu_op[ALU_SUB]}}  & sub_res)
                    | ({32{alu_op[ALU_SLT]}}  & slt_res)
                    | ({32{alu_op[ALU_SLTU]}} & sltu_res)
                    | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                    | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[ALU_SLL]}}  & (alu_src1 << alu_src2[4:0]))
                    | ({32{alu_op[ALU_SRL]}}  & (alu_src1 >> alu_src2[4:0]))
                    | ({32{alu_op[ALU_SRA]}}  & sra_res)
                    | ({32{alu_op[ALU_LUI]}}  & alu_src2);

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up folded into the last step so results are stable while DONE.
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 dvz_q, dvz_d;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] step_rem;
  logic [31:0] step_quo;

  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
  assign step_quo = {quo_q[30:0], ~diff[32]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dvz_d   = dvz_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          quo_d   = (sgn && dividend[31]) ? (~dividend + 32'd1) : dividend;
          dvs_d   = (sgn && divisor[31])  ? (~divisor + 32'd1)  : divisor;
          rem_d   = '0;
          q_neg_d = sgn && (dividend[31] ^ divisor[31]);
          r_neg_d = sgn && dividend[31];
          dvz_d   = (divisor == 32'd0);
        end
      end
      DIV_BUSY: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
          state_d = DIV_DONE;
          quo_d   = dvz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~step_quo + 32'd1) : step_quo);
          rem_d   = r_neg_q ? (~step_rem + 32'd1) : step_rem;
        end
      end
      DIV_DONE: begin
        if (ack) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath needs no reset: it is always reloaded on start.
  always_ff @(posedge clk) begin
    quo_q   <= quo_d;
    rem_q   <= rem_d;
    dvs_q   <= dvs_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    dvz_q   <= dvz_d;
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU/multiply in one cycle, iterative divide, data-SRAM request,
// and forwarding/stall information back to decode.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [4:0]                 es_to_ds_dest,
  output logic [31:0]                es_to_ds_value,
  output logic                       es_to_ds_stall
);

  logic          es_valid_q, es_valid_d;
  ds_to_es_bus_t bus_q, bus_d;

  logic        es_ready_go;
  logic        is_div, div_sgn, div_busy, div_done, div_wait;
  logic [31:0] div_quo, div_rem;
  logic [31:0] alu_result;
  logic [63:0] mul_s, mul_u;
  logic [31:0] es_result;
  logic        is_store;

  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) es_valid_d = ds_to_es_valid;
    if (ds_to_es_valid && es_allowin) bus_d = ds_to_es_bus_t'(ds_to_es_bus);
  end

  always_ff @(posedge clk) begin
    if (!resetn) es_valid_q <= 1'b0;
    else         es_valid_q <= es_valid_d;
  end

  always_ff @(posedge clk) bus_q <= bus_d;

  alu u_alu (
    .alu_op     (bus_q.alu_op),
    .alu_src1   (bus_q.src1),
    .alu_src2   (bus_q.src2),
    .alu_result (alu_result)
  );

  assign is_div  = |bus_q.md_op[MD_DIV:MD_MODU];
  assign div_sgn = bus_q.md_op[MD_DIV] | bus_q.md_op[MD_MOD];

  div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (es_valid_q && is_div),
    .sgn       (div_sgn),
    .dividend  (bus_q.src1),
    .divisor   (bus_q.src2),
    .ack       (es_to_ms_valid && ms_allowin),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Sign-extended operands give the signed product in the low 64 bits.
  assign mul_s = {{32{bus_q.src1[31]}}, bus_q.src1} * {{32{bus_q.src2[31]}}, bus_q.src2};
  assign mul_u = {32'd0, bus_q.src1} * {32'd0, bus_q.src2};

  always_comb begin
    es_result = alu_result;
    if (bus_q.md_op[MD_MUL])                             es_result = mul_s[31:0];
    else if (bus_q.md_op[MD_MULH])                       es_result = mul_s[63:32];
    else if (bus_q.md_op[MD_MULHU])                      es_result = mul_u[63:32];
    else if (bus_q.md_op[MD_DIV] || bus_q.md_op[MD_DIVU]) es_result = div_quo;
    else if (bus_q.md_op[MD_MOD] || bus_q.md_op[MD_MODU]) es_result = div_rem;
  end

  assign es_ready_go    = is_div ? div_done : 1'b1;
  assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_to_ms_bus   = {bus_q.ld_op, bus_q.res_from_mem, bus_q.gr_we, bus_q.dest,
                           es_result, bus_q.pc};

  // Loads issue only in the transfer cycle so rdata lines up with the memory stage.
  assign is_store        = |bus_q.st_op;
  assign data_sram_en    = es_valid_q && ms_allowin && (bus_q.res_from_mem || is_store);
  assign data_sram_addr  = bus_q.src1 + bus_q.src2;
  assign data_sram_we    = (data_sram_en && is_store) ? st_mask(bus_q.st_op, data_sram_addr[1:0]) : 4'b0000;
  assign data_sram_wdata = st_data(bus_q.st_op, bus_q.rkd_value);

  assign div_wait       = is_div && (div_busy || !div_done);
  assign es_to_ds_dest  = (es_valid_q && bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign es_to_ds_value = (es_valid_q && bus_q.gr_we) ? es_result : 32'd0;
  assign es_to_ds_stall = es_valid_q && bus_q.gr_we && (bus_q.res_from_mem || div_wait);

endmodule
